cpu_mem_responder: RTL

- Memory-side responder for the CPU request unit's single-port memory interface.
- Accepts one read or write request at a time and holds mem_busy high while the request is in flight.
- Performs the access on a word-addressed synchronous SRAM macro with configurable wait states.
- Returns byte-masked read data in the single cycle mem_busy drops, which is the cycle in which the requester advances.

---
 rtl/cpu_mem_pkg.sv | 23 ++
 rtl/cpu_mem_responder_if.sv | 33 +++
 rtl/cpu_mem_responder.sv | 111 +++++++++++
 3 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and helpers for the CPU memory responder.
package cpu_mem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned SEL_W  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

  // Zero every byte lane whose select bit is clear.
  function automatic logic [WORD_W-1:0] byte_mask(input logic [SEL_W-1:0]  sel,
                                                  input logic [WORD_W-1:0] data);
    logic [WORD_W-1:0] masked;
    for (int i = 0; i < SEL_W; i++) begin
      masked[8*i +: 8] = sel[i] ? data[8*i +: 8] : 8'h00;
    end
    return masked;
  endfunction

endpackage

// File: rtl/cpu_mem_responder_if.sv
// Request/response bus between the CPU request unit (master) and the memory responder (slave).
interface cpu_mem_responder_if;
  import cpu_mem_pkg::*;

  logic              read_to_mem;
  logic              write_to_mem;
  logic [SEL_W-1:0]  sel_to_mem;
  logic [31:0]       adr_to_mem;
  logic [WORD_W-1:0] data_to_mem;
  logic              mem_busy;
  logic [WORD_W-1:0] data_from_mem;

  modport master (
    output read_to_mem,
    output write_to_mem,
    output sel_to_mem,
    output adr_to_mem,
    output data_to_mem,
    input  mem_busy,
    input  data_from_mem
  );

  modport slave (
    input  read_to_mem,
    input  write_to_mem,
    input  sel_to_mem,
    input  adr_to_mem,
    input  data_to_mem,
    output mem_busy,
    output data_from_mem
  );

endinterface

// File: rtl/cpu_mem_responder.sv
// Single-outstanding-request responder driving a word-addressed synchronous SRAM with wait states.
module cpu_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               nRst,
  cpu_mem_responder_if.slave bus,
  output logic               sram_en,
  output logic               sram_we,
  output logic [SEL_W-1:0]   sram_wmask,
  output logic [ADDR_W-1:0]  sram_addr,
  output logic [WORD_W-1:0]  sram_wdata,
  input  logic [WORD_W-1:0]  sram_rdata
);

  localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES);

  state_e             r_state;
  logic [3:0]         r_cnt;
  logic               r_write;
  logic [SEL_W-1:0]   r_sel;
  logic               r_in_range;
  logic [WORD_W-1:0]  r_rdata;
  logic               r_sram_en;
  logic               r_sram_we;
  logic [SEL_W-1:0]   r_sram_wmask;
  logic [ADDR_W-1:0]  r_sram_addr;
  logic [WORD_W-1:0]  r_sram_wdata;

  logic               w_req;
  logic               w_write;
  logic [32:0]        w_off;
  logic               w_in_range;

  assign w_req   = bus.read_to_mem | bus.write_to_mem;
  // A simultaneous read and write is treated as a write.
  assign w_write = bus.write_to_mem;

  // 33-bit offset so addresses below BASE_ADDR land far out of range instead of wrapping.
  assign w_off      = {1'b0, bus.adr_to_mem} - {1'b0, BASE_ADDR};
  assign w_in_range = w_off < (33'd1 << (ADDR_W + 2));

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state      <= StIdle;
      r_cnt        <= 4'd0;
      r_write      <= 1'b0;
      r_sel        <= '0;
      r_in_range   <= 1'b0;
      r_rdata      <= '0;
      r_sram_en    <= 1'b0;
      r_sram_we    <= 1'b0;
      r_sram_wmask <= '0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          r_rdata <= '0;
          if (w_req) begin
            r_write      <= w_write;
            r_sel        <= bus.sel_to_mem;
            r_in_range   <= w_in_range;
            r_cnt        <= WaitLoad;
            r_sram_en    <= w_in_range;
            r_sram_we    <= w_write;
            r_sram_wmask <= w_write ? bus.sel_to_mem : '0;
            r_sram_addr  <= w_off[ADDR_W+1:2];
            r_sram_wdata <= bus.data_to_mem;
            r_state      <= StAccess;
          end
        end
        StAccess: begin
          if (r_cnt == 4'd0) begin
            r_rdata      <= (r_write || !r_in_range) ? '0 : byte_mask(r_sel, sram_rdata);
            r_sram_en    <= 1'b0;
            r_sram_we    <= 1'b0;
            r_sram_wmask <= '0;
            r_state      <= StDone;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        StDone: begin
          // Requester advances this cycle; its next request is only seen back in idle.
          r_rdata <= '0;
          r_state <= StIdle;
        end
        default: begin
          r_rdata <= '0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  // Busy must rise combinationally with the request so the requester stalls immediately.
  assign bus.mem_busy      = (r_state == StIdle) ? w_req : (r_state == StAccess);
  assign bus.data_from_mem = r_rdata;

  assign sram_en    = r_sram_en;
  assign sram_we    = r_sram_we;
  assign sram_wmask = r_sram_wmask;
  assign sram_addr  = r_sram_addr;
  assign sram_wdata = r_sram_wdata;

endmodule
